jtframe_dual_ram_clr: RTL and testbench

Single-clock, dual-port RAM with per-byte write enables, selectable read-during-write behaviour, optional output register and a built-in clear sequencer that sweeps the whole array to a fixed value after reset or on request. It is the parametrised successor of the plain dual-port RAM and serves as palette, object and scroll memory in cores that need a known RAM state without relying on synthesis-time init files.

---
 rtl/jtframe_ram_pkg.sv | 12 +
 rtl/jtframe_ram_clrseq.sv | 63 ++++++
 rtl/jtframe_dual_ram_clr.sv | 149 ++++++++++++++
 tb/tb_jtframe_dual_ram_clr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ram_pkg.sv
// Shared constants and clear-sequencer state encoding for the jtframe RAM family.
package jtframe_ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/jtframe_ram_clrseq.sv
// Clear sequencer: sweeps every address once with clr_val after reset or a clr
// request, driving the port-0 write path while busy.
module jtframe_ram_clrseq
  import jtframe_ram_pkg::*;
#(
  parameter int             aw      = 10,
  parameter int             dw      = 16,
  parameter logic [dw-1:0]  clr_val = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic [aw-1:0] clr_addr,
  output logic [dw-1:0] clr_data,
  output logic          clr_we
);

  clr_state_t  r_state;
  clr_state_t  w_state_next;
  logic [aw:0] r_cnt;
  logic [aw:0] w_cnt_next;
  logic [aw:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + {{aw{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The extra counter bit flags the end of the sweep, so the address never wraps.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CLEAR: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc[aw]) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      IDLE: begin
        if (clr) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_cnt[aw-1:0];
  assign clr_data = clr_val;

endmodule

// File: rtl/jtframe_dual_ram_clr.sv
// Dual-port RAM with byte-lane writes, selectable read-during-write result,
// optional output register and a self-clearing sweep after reset or on request.
module jtframe_dual_ram_clr
  import jtframe_ram_pkg::*;
#(
  parameter int             dw      = 16,
  parameter int             aw      = 10,
  parameter int             rdw     = 0,
  parameter int             oreg    = 0,
  parameter logic [dw-1:0]  clr_val = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            busy,
  input  logic            cen0,
  input  logic            cen1,
  input  logic [aw-1:0]   addr0,
  input  logic [aw-1:0]   addr1,
  input  logic [dw-1:0]   data0,
  input  logic [dw-1:0]   data1,
  input  logic            we0,
  input  logic            we1,
  input  logic [dw/8-1:0] be0,
  input  logic [dw/8-1:0] be1,
  output logic [dw-1:0]   q0,
  output logic [dw-1:0]   q1
);

  localparam int NB    = dw / 8;
  localparam int DEPTH = 2 ** aw;

  logic [dw-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_clr_we;
  logic [aw-1:0] w_clr_addr;
  logic [dw-1:0] w_clr_data;

  jtframe_ram_clrseq #(
    .aw      (aw),
    .dw      (dw),
    .clr_val (clr_val)
  ) u_clrseq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (w_busy),
    .clr_addr (w_clr_addr),
    .clr_data (w_clr_data),
    .clr_we   (w_clr_we)
  );

  assign busy = w_busy;

  // Port 0 carries the sweep while busy; user writes on both ports are dropped then.
  logic [aw-1:0] w_waddr0;
  logic [dw-1:0] w_wdata0;
  logic [NB-1:0] w_lane0;
  logic [NB-1:0] w_lane1;

  assign w_waddr0 = w_busy ? w_clr_addr : addr0;
  assign w_wdata0 = w_busy ? w_clr_data : data0;
  assign w_lane0  = w_busy ? {NB{w_clr_we}} : ((cen0 && we0) ? be0 : '0);
  assign w_lane1  = (!w_busy && cen1 && we1) ? be1 : '0;

  // Port 0 is applied last so it wins lanes both ports enable on the same word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_lane1[i]) r_mem[addr1][8*i +: 8] <= data1[8*i +: 8];
      if (w_lane0[i]) r_mem[w_waddr0][8*i +: 8] <= w_wdata0[8*i +: 8];
    end
  end

  logic [dw-1:0] w_old0;
  logic [dw-1:0] w_old1;
  logic [dw-1:0] w_new0;
  logic [dw-1:0] w_new1;
  logic [dw-1:0] w_rd0;
  logic [dw-1:0] w_rd1;
  logic          w_hit00;
  logic          w_hit10;
  logic          w_hit01;
  logic          w_hit11;

  assign w_old0  = r_mem[addr0];
  assign w_old1  = r_mem[addr1];
  assign w_hit00 = (w_waddr0 == addr0);
  assign w_hit10 = (addr1 == addr0);
  assign w_hit01 = (w_waddr0 == addr1);
  assign w_hit11 = 1'b1;

  // Post-write view of each read word, lane by lane, with port-0 priority.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_new0[8*gi +: 8] = (w_lane0[gi] && w_hit00) ? w_wdata0[8*gi +: 8] :
                                 (w_lane1[gi] && w_hit10) ? data1[8*gi +: 8] :
                                                            w_old0[8*gi +: 8];
      assign w_new1[8*gi +: 8] = (w_lane0[gi] && w_hit01) ? w_wdata0[8*gi +: 8] :
                                 (w_lane1[gi] && w_hit11) ? data1[8*gi +: 8] :
                                                            w_old1[8*gi +: 8];
    end
  endgenerate

  assign w_rd0 = (rdw == RDW_NEW) ? w_new0 : w_old0;
  assign w_rd1 = (rdw == RDW_NEW) ? w_new1 : w_old1;

  logic [dw-1:0] r_q0;
  logic [dw-1:0] r_q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else if (w_busy) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else begin
      if (cen0) r_q0 <= w_rd0;
      if (cen1) r_q1 <= w_rd1;
    end
  end

  generate
    if (oreg != 0) begin : g_oreg
      logic [dw-1:0] r_oq0;
      logic [dw-1:0] r_oq1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_oq0 <= '0;
          r_oq1 <= '0;
        end else if (w_busy) begin
          r_oq0 <= '0;
          r_oq1 <= '0;
        end else begin
          if (cen0) r_oq0 <= r_q0;
          if (cen1) r_oq1 <= r_q1;
        end
      end
      assign q0 = r_oq0;
      assign q1 = r_oq1;
    end else begin : g_noreg
      assign q0 = r_q0;
      assign q1 = r_q1;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Scoreboard bench for jtframe_dual_ram_clr: three instances (old-data, new-data,
// new-data with output register) share stimulus; a monitor checks due entries.
module tb_jtframe_dual_ram_clr;

  localparam logic [15:0] CV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n, clr, cen0, cen1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [1:0]  be0, be1;
  logic [15:0] q0_w [3];
  logic [15:0] q1_w [3];
  logic        busy_w [3];

  always #5 clk = ~clk;

  jtframe_dual_ram_clr #(.dw(16), .aw(4), .rdw(0), .oreg(0), .clr_val(CV)) u_old (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_w[0]),
    .cen0(cen0), .cen1(cen1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .q0(q0_w[0]), .q1(q1_w[0]));

  jtframe_dual_ram_clr #(.dw(16), .aw(4), .rdw(1), .oreg(0), .clr_val(CV)) u_new (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_w[1]),
    .cen0(cen0), .cen1(cen1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .q0(q0_w[1]), .q1(q1_w[1]));

  jtframe_dual_ram_clr #(.dw(16), .aw(4), .rdw(1), .oreg(1), .clr_val(CV)) u_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_w[2]),
    .cen0(cen0), .cen1(cen1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .q0(q0_w[2]), .q1(q1_w[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = q0, 1 = q1, 2 = busy
  typedef struct {
    int          due;
    int          dut;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_cur;
  logic [15:0] mon_act;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        tb_done = 1'b0;

  function automatic int lat(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic push(input int l, input int d, input int k, input logic [15:0] e, input string nm);
    exp_t it;
    int   idx;
    it.due  = cyc + l;
    it.dut  = d;
    it.kind = k;
    it.exp  = e;
    it.name = nm;
    idx = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].due > it.due) begin
        idx = i;
        break;
      end
    end
    sbq.insert(idx, it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cen0 = 1'b1; cen1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    be0 = 2'b00; be1 = 2'b00; clr = 1'b0;
  endtask

  task automatic wr(input logic w0, input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] b0,
                    input logic w1, input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] b1);
    cen0 = 1'b1; cen1 = 1'b1;
    we0 = w0; addr0 = a0; data0 = d0; be0 = b0;
    we1 = w1; addr1 = a1; data1 = d1; be1 = b1;
  endtask

  // Expected read results for the addresses currently on the bus.
  task automatic exp_rd(input logic [15:0] e0o, input logic [15:0] e0n,
                        input logic [15:0] e1o, input logic [15:0] e1n, input string nm);
    for (int d = 0; d < 3; d++) begin
      push(lat(d), d, 0, (d == 0) ? e0o : e0n, {nm, "_q0"});
      push(lat(d), d, 1, (d == 0) ? e1o : e1n, {nm, "_q1"});
    end
  endtask

  task automatic exp_zero(input int l, input string nm);
    for (int d = 0; d < 3; d++) begin
      push(l, d, 0, 16'h0000, {nm, "_q0"});
      push(l, d, 1, 16'h0000, {nm, "_q1"});
    end
  endtask

  task automatic exp_busy(input int l, input logic v, input string nm);
    for (int d = 0; d < 3; d++) push(l, d, 2, {15'd0, v}, nm);
  endtask

  task automatic read_all(input int a2_val, input string nm);
    for (int a = 0; a < 16; a++) begin
      logic [15:0] e0, e1;
      set_idle();
      addr0 = a[3:0];
      addr1 = 4'(15 - a);
      e0 = (a2_val >= 0 && a == 2) ? 16'(a2_val) : CV;
      e1 = (a2_val >= 0 && (15 - a) == 2) ? 16'(a2_val) : CV;
      exp_rd(e0, e0, e1, e1, $sformatf("%s%0d", nm, a));
      tick();
    end
  endtask

  // Monitor: compares every entry whose due cycle has arrived.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_cur = sbq.pop_front();
      case (mon_cur.kind)
        0:       mon_act = q0_w[mon_cur.dut];
        1:       mon_act = q1_w[mon_cur.dut];
        default: mon_act = {15'd0, busy_w[mon_cur.dut]};
      endcase
      n_chk = n_chk + 1;
      if (mon_cur.due < cyc)
        $display("FAIL %s dut%0d: sampled late at cycle %0d (due %0d)", mon_cur.name, mon_cur.dut, cyc, mon_cur.due);
      else if (mon_act === mon_cur.exp) begin
        n_pass = n_pass + 1;
        $display("ok   %s dut%0d: got %h", mon_cur.name, mon_cur.dut, mon_act);
      end else
        $display("FAIL %s dut%0d: got %h expected %h", mon_cur.name, mon_cur.dut, mon_act, mon_cur.exp);
    end
    if (tb_done) begin
      while (sbq.size() > 0) begin
        mon_cur = sbq.pop_front();
        n_chk = n_chk + 1;
        $display("FAIL %s dut%0d: never observed (due %0d)", mon_cur.name, mon_cur.dut, mon_cur.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    tick(); tick();

    // Reset: outputs 0, busy high
    addr0 = 4'd3; addr1 = 4'd4;
    exp_zero(0, "rst");
    exp_busy(0, 1'b1, "rst_busy");
    tick();

    // Release: busy for exactly 16 cycles, outputs 0 mid-sweep
    rst_n = 1'b1;
    exp_busy(0, 1'b1, "rel_busy_first");
    exp_busy(15, 1'b1, "rel_busy_last");
    exp_busy(16, 1'b0, "rel_busy_end");
    exp_zero(8, "rel_sweep");
    repeat (16) tick();
    read_all(-1, "init_rd");

    // Byte-lane write over the clear value
    wr(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    set_idle(); addr0 = 4'd3; addr1 = 4'd3;
    exp_rd(16'hA534, 16'hA534, 16'hA534, 16'hA534, "be_lo"); tick();

    // Same-address writes from both ports
    wr(1'b1, 4'd5, 16'h1111, 2'b11, 1'b1, 4'd5, 16'h2222, 2'b10); tick();
    set_idle(); addr0 = 4'd5; addr1 = 4'd5;
    exp_rd(16'h1111, 16'h1111, 16'h1111, 16'h1111, "dual_p0wins"); tick();
    wr(1'b1, 4'd5, 16'h1111, 2'b01, 1'b1, 4'd5, 16'h2222, 2'b10); tick();
    set_idle(); addr0 = 4'd5; addr1 = 4'd5;
    exp_rd(16'h2211, 16'h2211, 16'h2211, 16'h2211, "dual_merge"); tick();
    wr(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b1, 4'd5, 16'h2233, 2'b01); tick();
    set_idle(); addr0 = 4'd5; addr1 = 4'd5;
    exp_rd(16'h2233, 16'h2233, 16'h2233, 16'h2233, "be_zero_p1lo"); tick();

    // Read-during-write: old vs new data
    wr(1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b0, 4'd7, 16'h0, 2'b00);
    exp_rd(CV, 16'hBEEF, CV, 16'hBEEF, "rdw7"); tick();
    set_idle(); addr0 = 4'd7; addr1 = 4'd7;
    exp_rd(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, "after7"); tick();

    // Read-during-write with cross-port merge
    wr(1'b1, 4'd6, 16'h00CC, 2'b01, 1'b1, 4'd6, 16'hDDEE, 2'b11);
    exp_rd(CV, 16'hDDCC, CV, 16'hDDCC, "rdw6_merge"); tick();
    set_idle(); addr0 = 4'd6; addr1 = 4'd6;
    exp_rd(16'hDDCC, 16'hDDCC, 16'hDDCC, 16'hDDCC, "after6"); tick();

    // cen0 low holds q0 and its pipeline
    set_idle(); addr0 = 4'd3; addr1 = 4'd7;
    exp_rd(16'hA534, 16'hA534, 16'hBEEF, 16'hBEEF, "pre_hold"); tick();
    exp_rd(16'hA534, 16'hA534, 16'hBEEF, 16'hBEEF, "pre_hold2"); tick();
    for (int k = 0; k < 2; k++) begin
      cen0 = 1'b0; addr0 = 4'd7;
      for (int d = 0; d < 3; d++) push(1, d, 0, 16'hA534, "hold_q0");
      tick();
    end
    set_idle(); addr0 = 4'd7;
    exp_rd(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, "unhold"); tick();

    // clr pulse: 16 busy cycles, writes dropped, repeat clr ignored
    set_idle(); clr = 1'b1;
    exp_busy(0, 1'b0, "clr_pre");
    exp_busy(1, 1'b1, "clr_first");
    exp_busy(16, 1'b1, "clr_last");
    exp_busy(17, 1'b0, "clr_end");
    tick();
    for (int k = 1; k <= 16; k++) begin
      set_idle();
      if (k == 3) wr(1'b1, 4'd9, 16'h0000, 2'b11, 1'b1, 4'd10, 16'h0000, 2'b11);
      if (k == 5) clr = 1'b1;
      if (k == 8) exp_zero(1, "clr_sweep");
      if (k == 16) wr(1'b1, 4'd4, 16'h4444, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00);
      tick();
    end
    set_idle();
    wr(1'b1, 4'd2, 16'h1234, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    read_all(16'h1234, "post_clr");

    // Reset mid-sweep restarts a full sweep
    set_idle();
    wr(1'b1, 4'd12, 16'h5A5A, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    set_idle(); clr = 1'b1; tick();
    set_idle();
    repeat (6) tick();
    rst_n = 1'b0;
    exp_zero(0, "mid_rst");
    exp_busy(0, 1'b1, "mid_rst_busy");
    tick();
    exp_zero(0, "mid_rst2");
    tick();
    rst_n = 1'b1;
    exp_busy(0, 1'b1, "re_busy_first");
    exp_busy(15, 1'b1, "re_busy_last");
    exp_busy(16, 1'b0, "re_busy_end");
    repeat (16) tick();
    read_all(-1, "post_rst");

    repeat (4) tick();
    tb_done = 1'b1;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
